// File: rtl/rom_stream_reader_if.sv
//==============================================================================
// Module   : rom_stream_reader_if
// Brief    : Bundles the control, ROM read port and output stream signals of
//            rom_stream_reader. The master modport is the reader itself; the
//            slave modport is its environment (ROM, controller and consumer).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface rom_stream_reader_if #(
    parameter int p_ADDR_WIDTH = 4,
    parameter int p_DATA_WIDTH = 8
);
    // Sweep control
    logic                    i_START;
    logic [p_ADDR_WIDTH-1:0] i_BASE_ADDR;
    logic [p_ADDR_WIDTH:0]   i_LENGTH;
    logic                    o_BUSY;
    logic                    o_DONE;

    // ROM read port
    logic                    o_ROM_READ_ENABLE;
    logic [p_ADDR_WIDTH-1:0] o_ROM_ADDRESS;
    logic [p_DATA_WIDTH-1:0] i_ROM_DATA;

    // Output stream
    logic [p_DATA_WIDTH-1:0] o_DATA;
    logic                    o_VALID;
    logic                    o_LAST;
    logic                    i_READY;

    modport master (
        input  i_START, i_BASE_ADDR, i_LENGTH, i_ROM_DATA, i_READY,
        output o_BUSY, o_DONE, o_ROM_READ_ENABLE, o_ROM_ADDRESS,
               o_DATA, o_VALID, o_LAST
    );

    modport slave (
        output i_START, i_BASE_ADDR, i_LENGTH, i_ROM_DATA, i_READY,
        input  o_BUSY, o_DONE, o_ROM_READ_ENABLE, o_ROM_ADDRESS,
               o_DATA, o_VALID, o_LAST
    );
endinterface

`default_nettype wire

// File: rtl/rom_stream_reader.sv
//==============================================================================
// Module   : rom_stream_reader
// Brief    : Sweeps a run of consecutive words out of a synchronous ROM and
//            presents them as a valid/ready stream through a 4-entry buffer.
//            Reads are only issued while buffered plus in-flight words leave
//            room, so the buffer can never overflow.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rom_stream_reader #(
    parameter int p_ADDR_WIDTH = 4,
    parameter int p_DATA_WIDTH = 8
) (
    input  wire logic         i_CLK,
    input  wire logic         i_RESET_N,
    rom_stream_reader_if.master bus
);
    localparam int                    c_DEPTH   = 4;
    localparam logic [p_ADDR_WIDTH:0] c_LEN_ONE = (p_ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [p_ADDR_WIDTH-1:0] base_q, base_d;
    logic [p_ADDR_WIDTH:0]   len_q, len_d;
    logic [p_ADDR_WIDTH:0]   issued_q, issued_d;
    logic                    rd_en_q, rd_en_d;
    logic                    rd_last_q, rd_last_d;
    logic [p_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                    done_q, done_d;

    // Second in-flight stage: the ROM has sampled this read, data is on the bus
    logic                    inflight_q;
    logic                    inflight_last_q;

    // Output buffer
    logic [p_DATA_WIDTH-1:0] buf_data_q [c_DEPTH];
    logic                    buf_last_q [c_DEPTH];
    logic [1:0]              wr_ptr_q, rd_ptr_q;
    logic [2:0]              count_q;

    logic                    w_valid;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_head_last;
    logic [2:0]              w_committed;
    logic                    w_credit;
    logic [p_ADDR_WIDTH:0]   w_issued_next;

    assign w_valid       = (count_q != 3'd0);
    assign w_push        = inflight_q;
    assign w_pop         = w_valid & bus.i_READY;
    assign w_head_last   = buf_last_q[rd_ptr_q];
    assign w_committed   = count_q + {2'b00, rd_en_q} + {2'b00, inflight_q};
    assign w_credit      = (w_committed < 3'd4);
    assign w_issued_next = issued_q + c_LEN_ONE;

    // Sweep state, read-issue registers and done pulse
    always_ff @(posedge i_CLK) begin
        if (!i_RESET_N) begin
            state_q         <= S_IDLE;
            base_q          <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            rd_en_q         <= 1'b0;
            rd_last_q       <= 1'b0;
            addr_q          <= '0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            len_q           <= len_d;
            issued_q        <= issued_d;
            rd_en_q         <= rd_en_d;
            rd_last_q       <= rd_last_d;
            addr_q          <= addr_d;
            done_q          <= done_d;
            inflight_q      <= rd_en_q;
            inflight_last_q <= rd_last_q;
        end
    end

    // Next-state logic: accept starts, issue credited reads, finish on last transfer
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        issued_d  = issued_q;
        rd_en_d   = 1'b0;
        rd_last_d = 1'b0;
        addr_d    = addr_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_START) begin
                    if (bus.i_LENGTH != '0) begin
                        base_d   = bus.i_BASE_ADDR;
                        len_d    = bus.i_LENGTH;
                        issued_d = '0;
                        state_d  = S_READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (w_credit) begin
                    rd_en_d   = 1'b1;
                    addr_d    = base_q + issued_q[p_ADDR_WIDTH-1:0];
                    rd_last_d = (w_issued_next == len_q);
                    issued_d  = w_issued_next;
                    if (w_issued_next == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pop && w_head_last) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output FIFO: capture returning ROM data, release on stream transfer
    always_ff @(posedge i_CLK) begin
        if (!i_RESET_N) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                buf_data_q[i] <= '0;
                buf_last_q[i] <= 1'b0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (w_push) begin
                buf_data_q[wr_ptr_q] <= bus.i_ROM_DATA;
                buf_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q             <= wr_ptr_q + 2'd1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_q + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

    assign bus.o_BUSY            = (state_q != S_IDLE);
    assign bus.o_DONE            = done_q;
    assign bus.o_ROM_READ_ENABLE = rd_en_q;
    assign bus.o_ROM_ADDRESS     = addr_q;
    assign bus.o_VALID           = w_valid;
    assign bus.o_DATA            = w_valid ? buf_data_q[rd_ptr_q] : '0;
    assign bus.o_LAST            = w_valid & w_head_last;

endmodule

`default_nettype wire
